// File: rtl/port_arbiter_pkg.sv
// Shared constants for the port arbiter: word width, FSM encodings, halt address.
package port_arbiter_pkg;

    localparam int WORD_SIZE      = 8;
    localparam int CNT_W          = 4;
    localparam int PORT_HALT_ADDR = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_WAIT  = 2'd2,
        ST_ACK   = 2'd3
    } arb_state_e;

endpackage

// File: rtl/port_arb_rr.sv
// Combinational 2-way round-robin picker: one-hot grant, pointer breaks ties.
module port_arb_rr
    import port_arbiter_pkg::*;
(
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = ptr ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/port_arbiter.sv
// Two-requester arbiter serialising get/set transactions onto one port block.
// Latency: request to ack is 2 + LATENCY cycles, one transaction in flight.
// Backpressure: requesters hold req until ack; optional PORT_ARB_HALT_EN halts grants after a write to address 0.
module port_arbiter #(
    parameter int WORD_SIZE = port_arbiter_pkg::WORD_SIZE,
    parameter int LATENCY   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [1:0]             req,
    input  logic [1:0]             we,
    input  logic [2*WORD_SIZE-1:0] addr,
    input  logic [2*WORD_SIZE-1:0] wdata,
    output logic [1:0]             ack,
    output logic [2*WORD_SIZE-1:0] rdata,
    output logic [WORD_SIZE-1:0]   portaddr,
    output logic [WORD_SIZE-1:0]   portval,
    output logic                   portget,
    output logic                   portset,
    input  logic [WORD_SIZE-1:0]   portout,
    output logic                   busy,
    output logic                   halted
);
    import port_arbiter_pkg::*;

    arb_state_e             state_q, state_d;
    logic                   ptr_q, ptr_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [1:0]             gnt_q, gnt_d, gnt_pick;
    logic                   we_q, we_d;
    logic [WORD_SIZE-1:0]   addr_q, addr_d;
    logic [WORD_SIZE-1:0]   wdata_q, wdata_d;
    logic [2*WORD_SIZE-1:0] rdata_q, rdata_d;
    logic                   halt_blk;
    logic                   sample;

    port_arb_rr u_rr (
        .req (req),
        .ptr (ptr_q),
        .gnt (gnt_pick)
    );

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
        gnt_d   = gnt_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rdata_d = rdata_q;
        sample  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if ((req != 2'b00) && !halt_blk) begin
                    gnt_d   = gnt_pick;
                    we_d    = gnt_pick[1] ? we[1] : we[0];
                    addr_d  = gnt_pick[1] ? addr[2*WORD_SIZE-1:WORD_SIZE]
                                          : addr[WORD_SIZE-1:0];
                    wdata_d = gnt_pick[1] ? wdata[2*WORD_SIZE-1:WORD_SIZE]
                                          : wdata[WORD_SIZE-1:0];
                    state_d = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // With no port latency the read data is already valid alongside the strobe.
                if (LATENCY == 0) begin
                    sample  = !we_q;
                    state_d = ST_ACK;
                end else begin
                    cnt_d   = CNT_W'(LATENCY);
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    sample  = !we_q;
                    state_d = ST_ACK;
                end
            end
            ST_ACK: begin
                ptr_d   = ~ptr_q;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        if (sample) begin
            if (gnt_q[1]) begin
                rdata_d[2*WORD_SIZE-1:WORD_SIZE] = portout;
            end else begin
                rdata_d[WORD_SIZE-1:0] = portout;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            gnt_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            gnt_q   <= gnt_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
        end
    end

`ifdef PORT_ARB_HALT_EN
    logic halted_q, halted_d;

    always_comb begin
        halted_d = halted_q;
        if ((state_q == ST_ACK) && we_q && (addr_q == WORD_SIZE'(PORT_HALT_ADDR))) begin
            halted_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            halted_q <= 1'b0;
        end else begin
            halted_q <= halted_d;
        end
    end

    assign halt_blk = halted_q;
`else
    assign halt_blk = 1'b0;
`endif

    assign halted   = halt_blk;
    assign busy     = (state_q != ST_IDLE);
    assign portget  = (state_q == ST_ISSUE) && !we_q;
    assign portset  = (state_q == ST_ISSUE) && we_q;
    assign portaddr = busy ? addr_q : '0;
    assign portval  = busy ? wdata_q : '0;
    assign ack      = (state_q == ST_ACK) ? gnt_q : 2'b00;
    assign rdata    = rdata_q;

endmodule
